// File: rtl/core_config_pkg.sv
// core_config_pkg: core-wide configuration shared by the commit stage.
//   XLEN         - datapath width
//   REG_ADDR_W   - register index width
//   COMMIT_UNITS - number of execution units feeding the commit arbiter
//   commit_state_t - commit FSM states (RUN, HALT)
package core_config_pkg;

    localparam int unsigned XLEN         = 32;
    localparam int unsigned REG_ADDR_W   = 5;
    localparam int unsigned COMMIT_UNITS = 5;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } commit_state_t;

endpackage

// File: rtl/commit_arbiter_if.sv
// commit_arbiter_if: commit handshake between the execution units and the
// commit arbiter.
//   u_req/u_valid/u_error/u_res/u_rd - per-unit result, driven by the units
//   u_clear                          - one-hot grant back to the units
//   modport master - execution-unit side
//   modport slave  - arbiter side
interface commit_arbiter_if
    import core_config_pkg::*;
#(
    parameter int unsigned N_UNITS = COMMIT_UNITS,
    parameter int unsigned DATA_W  = XLEN,
    parameter int unsigned ADDR_W  = REG_ADDR_W
);

    logic [N_UNITS-1:0]             u_req;
    logic [N_UNITS-1:0]             u_valid;
    logic [N_UNITS-1:0]             u_error;
    logic [N_UNITS-1:0][DATA_W-1:0] u_res;
    logic [N_UNITS-1:0][ADDR_W-1:0] u_rd;
    logic [N_UNITS-1:0]             u_clear;

    modport master (
        output u_req, u_valid, u_error, u_res, u_rd,
        input  u_clear
    );

    modport slave (
        input  u_req, u_valid, u_error, u_res, u_rd,
        output u_clear
    );

endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter with an internal rotating pointer.
//   clk, rst - clock, async active-high reset
//   req      - request vector
//   en       - arbitration enable; no grant and no pointer move when low
//   gnt      - one-hot grant (combinational)
//   gnt_idx  - index of the granted requester (combinational)
// The pointer moves to one past the winner only when a grant is issued.
module rr_arbiter #(
    parameter int unsigned N = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic                 en,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx
);

    localparam int unsigned IDX_W = $clog2(N);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic             found;
    int unsigned      cand;

    // Scan from ptr_q upward, wrapping, and take the first requester.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        ptr_d   = ptr_q;
        found   = 1'b0;
        cand    = 0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = (32'(ptr_q) + i) % N;
            if (en && !found && req[cand]) begin
                found       = 1'b1;
                gnt[cand]   = 1'b1;
                gnt_idx     = IDX_W'(cand);
                ptr_d       = (cand == N - 1) ? '0 : IDX_W'(cand + 1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/commit_arbiter.sv
// commit_arbiter: picks one finished execution-unit result per cycle
// (round robin) and writes it to the register file through a registered
// writeback port. A faulting result is reported on exc_* and halts commits
// until exc_ack.
//   clk, rst                      - clock, async active-high reset
//   cif (slave)                   - unit results in, one-hot u_clear out
//   wb_stall                      - register file busy, no grant this cycle
//   rf_we/rf_waddr/rf_wdata       - registered writeback
//   exc_valid/exc_unit/exc_data   - registered pending fault
//   exc_ack                       - trap logic consumed the fault
// Optional feature macro COMMIT_FORWARD_EN: adds fwd_valid/fwd_rd/fwd_data,
// a combinational copy of the write that rf_* will carry next cycle.
module commit_arbiter
    import core_config_pkg::*;
#(
    parameter int unsigned N_UNITS    = COMMIT_UNITS,
    parameter int unsigned DATA_W     = XLEN,
    parameter int unsigned ADDR_W     = REG_ADDR_W
) (
    input  logic                       clk,
    input  logic                       rst,
    commit_arbiter_if.slave            cif,
    input  logic                       wb_stall,
    output logic                       rf_we,
    output logic [ADDR_W-1:0]          rf_waddr,
    output logic [DATA_W-1:0]          rf_wdata,
    output logic                       exc_valid,
    output logic [$clog2(N_UNITS)-1:0] exc_unit,
    output logic [DATA_W-1:0]          exc_data,
`ifdef COMMIT_FORWARD_EN
    output logic                       fwd_valid,
    output logic [ADDR_W-1:0]          fwd_rd,
    output logic [DATA_W-1:0]          fwd_data,
`endif
    input  logic                       exc_ack
);

    localparam int unsigned IDX_W = $clog2(N_UNITS);

    commit_state_t     state_q;
    logic              rf_we_q;
    logic [ADDR_W-1:0] rf_waddr_q;
    logic [DATA_W-1:0] rf_wdata_q;
    logic              exc_valid_q;
    logic [IDX_W-1:0]  exc_unit_q;
    logic [DATA_W-1:0] exc_data_q;

    logic              arb_en_c;
    logic [N_UNITS-1:0] gnt_c;
    logic [IDX_W-1:0]  gnt_idx_c;
    logic              gnt_any_c;
    logic              fault_c;
    logic              wr_c;

    // Grants only in RUN with the register file ready; exc_ack is not involved.
    assign arb_en_c = (state_q == RUN) && !wb_stall;

    rr_arbiter #(
        .N (N_UNITS)
    ) u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (cif.u_req),
        .en      (arb_en_c),
        .gnt     (gnt_c),
        .gnt_idx (gnt_idx_c)
    );

    assign cif.u_clear = gnt_c;
    assign gnt_any_c   = |gnt_c;
    assign fault_c     = gnt_any_c && cif.u_error[gnt_idx_c];
    // rd = 0 and non-writing results are consumed without a register write.
    assign wr_c        = gnt_any_c && !cif.u_error[gnt_idx_c]
                         && cif.u_valid[gnt_idx_c]
                         && (cif.u_rd[gnt_idx_c] != '0);

`ifdef COMMIT_FORWARD_EN
    assign fwd_valid = wr_c;
    assign fwd_rd    = cif.u_rd[gnt_idx_c];
    assign fwd_data  = cif.u_res[gnt_idx_c];
`endif

    // Commit FSM with registered writeback and fault outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            exc_valid_q <= 1'b0;
            exc_unit_q  <= '0;
            exc_data_q  <= '0;
        end else begin
            rf_we_q <= wr_c;
            if (wr_c) begin
                rf_waddr_q <= cif.u_rd[gnt_idx_c];
                rf_wdata_q <= cif.u_res[gnt_idx_c];
            end
            case (state_q)
                RUN: begin
                    if (fault_c) begin
                        state_q     <= HALT;
                        exc_valid_q <= 1'b1;
                        exc_unit_q  <= gnt_idx_c;
                        exc_data_q  <= cif.u_res[gnt_idx_c];
                    end
                end
                HALT: begin
                    if (exc_ack) begin
                        state_q     <= RUN;
                        exc_valid_q <= 1'b0;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign rf_we     = rf_we_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign exc_valid = exc_valid_q;
    assign exc_unit  = exc_unit_q;
    assign exc_data  = exc_data_q;

endmodule

// File: tb/tb_commit_arbiter.sv
// tb_commit_arbiter: directed scenarios plus randomized traffic, checked
// against a behavioural model of the commit rules.
module tb_commit_arbiter;
    import core_config_pkg::*;

    localparam int unsigned N  = COMMIT_UNITS;
    localparam int unsigned IW = $clog2(N);

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  wb_stall;
    logic                  exc_ack;
    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_waddr;
    logic [XLEN-1:0]       rf_wdata;
    logic                  exc_valid;
    logic [IW-1:0]         exc_unit;
    logic [XLEN-1:0]       exc_data;
`ifdef COMMIT_FORWARD_EN
    logic                  fwd_valid;
    logic [REG_ADDR_W-1:0] fwd_rd;
    logic [XLEN-1:0]       fwd_data;
`endif

    always #5 clk = ~clk;

    commit_arbiter_if cif ();

    commit_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .cif       (cif),
        .wb_stall  (wb_stall),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .exc_valid (exc_valid),
        .exc_unit  (exc_unit),
        .exc_data  (exc_data),
`ifdef COMMIT_FORWARD_EN
        .fwd_valid (fwd_valid),
        .fwd_rd    (fwd_rd),
        .fwd_data  (fwd_data),
`endif
        .exc_ack   (exc_ack)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int                    m_ptr;
    bit                    m_halt;
    bit                    m_we;
    logic [REG_ADDR_W-1:0] m_waddr;
    logic [XLEN-1:0]       m_wdata;
    bit                    m_exc;
    int                    m_exc_unit;
    logic [XLEN-1:0]       m_exc_data;

    logic [N-1:0]          last_clear;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr      = 0;
        m_halt     = 0;
        m_we       = 0;
        m_waddr    = '0;
        m_wdata    = '0;
        m_exc      = 0;
        m_exc_unit = 0;
        m_exc_data = '0;
    endtask

    task automatic clear_inputs();
        cif.u_req   = '0;
        cif.u_valid = '0;
        cif.u_error = '0;
        cif.u_res   = '0;
        cif.u_rd    = '0;
        wb_stall    = 1'b0;
        exc_ack     = 1'b0;
    endtask

    task automatic set_unit(input int k, input bit valid, input bit err,
                            input logic [XLEN-1:0] res, input logic [REG_ADDR_W-1:0] rd);
        cif.u_req[k]   = 1'b1;
        cif.u_valid[k] = valid;
        cif.u_error[k] = err;
        cif.u_res[k]   = res;
        cif.u_rd[k]    = rd;
    endtask

    // One clock: check the grant before the edge, registered outputs after it.
    task automatic step(output int g);
        logic [N-1:0] expc;
        g = -1;
        #1;
        if (!m_halt && !wb_stall) begin
            for (int i = 0; i < int'(N); i++) begin
                int j;
                j = (m_ptr + i) % int'(N);
                if (g < 0 && cif.u_req[j]) g = j;
            end
        end
        expc = '0;
        if (g >= 0) expc[g] = 1'b1;
        last_clear = cif.u_clear;
        check("u_clear", 64'(cif.u_clear), 64'(expc));
        if (g >= 0) begin
            if (cif.u_error[g]) begin
                m_we       = 0;
                m_exc      = 1;
                m_halt     = 1;
                m_exc_unit = g;
                m_exc_data = cif.u_res[g];
            end else begin
                m_we = cif.u_valid[g] && (cif.u_rd[g] != '0);
                if (m_we) begin
                    m_waddr = cif.u_rd[g];
                    m_wdata = cif.u_res[g];
                end
            end
            m_ptr = (g + 1) % int'(N);
        end else begin
            m_we = 0;
            if (m_halt && exc_ack) begin
                m_halt = 0;
                m_exc  = 0;
            end
        end
        @(posedge clk);
        #1;
        check("rf_we", 64'(rf_we), 64'(m_we));
        if (m_we) begin
            check("rf_waddr", 64'(rf_waddr), 64'(m_waddr));
            check("rf_wdata", 64'(rf_wdata), 64'(m_wdata));
        end
        check("exc_valid", 64'(exc_valid), 64'(m_exc));
        if (m_exc) begin
            check("exc_unit", 64'(exc_unit), 64'(m_exc_unit));
            check("exc_data", 64'(exc_data), 64'(m_exc_data));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int g;
        rst = 1'b1;
        clear_inputs();
        model_reset();
        last_clear = '0;
        repeat (2) @(negedge clk);
        check("rst_clear",     64'(cif.u_clear), 64'(0));
        check("rst_rf_we",     64'(rf_we),       64'(0));
        check("rst_rf_waddr",  64'(rf_waddr),    64'(0));
        check("rst_rf_wdata",  64'(rf_wdata),    64'(0));
        check("rst_exc_valid", 64'(exc_valid),   64'(0));
        check("rst_exc_unit",  64'(exc_unit),    64'(0));
        check("rst_exc_data",  64'(exc_data),    64'(0));
        rst = 1'b0;

        // Single request
        set_unit(2, 1'b1, 1'b0, 32'hDEADBEEF, 5'd5);
        step(g);
        check("single_clear", 64'(last_clear), 64'(5'b00100));
        check("single_we",    64'(rf_we),      64'(1));
        check("single_waddr", 64'(rf_waddr),   64'(5));
        check("single_wdata", 64'(rf_wdata),   64'hDEADBEEF);
        clear_inputs();

        // Fairness from reset: all units request continuously
        do_reset();
        for (int k = 0; k < int'(N); k++)
            set_unit(k, 1'b1, 1'b0, $urandom, REG_ADDR_W'(k + 1));
        for (int i = 0; i < 6; i++) begin
            logic [N-1:0] e;
            e = '0;
            e[i % int'(N)] = 1'b1;
            step(g);
            check("fair_clear", 64'(last_clear), 64'(e));
            check("fair_we",    64'(rf_we),      64'(1));
        end
        clear_inputs();

        // rd = 0 and valid = 0: consumed without a write
        set_unit(1, 1'b1, 1'b0, 32'h1234, 5'd0);
        step(g);
        check("rd0_clear", 64'(last_clear), 64'(5'b00010));
        check("rd0_we",    64'(rf_we),      64'(0));
        set_unit(1, 1'b0, 1'b0, 32'h5678, 5'd3);
        step(g);
        check("nv_clear", 64'(last_clear), 64'(5'b00010));
        check("nv_we",    64'(rf_we),      64'(0));
        clear_inputs();

        // Fault at unit 4 with unit 0 also requesting
        set_unit(4, 1'b1, 1'b1, 32'h80000002, 5'd6);
        set_unit(0, 1'b1, 1'b0, 32'hA5A5A5A5, 5'd7);
        step(g);
        check("fault_clear", 64'(last_clear), 64'(5'b10000));
        check("fault_valid", 64'(exc_valid),  64'(1));
        check("fault_unit",  64'(exc_unit),   64'(4));
        check("fault_data",  64'(exc_data),   64'h80000002);
        check("fault_we",    64'(rf_we),      64'(0));
        cif.u_req[4] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(g);
            check("halt_clear", 64'(last_clear), 64'(0));
        end
        exc_ack = 1'b1;
        step(g);
        check("ack_clear", 64'(last_clear), 64'(0));
        check("ack_valid", 64'(exc_valid),  64'(0));
        exc_ack = 1'b0;
        step(g);
        check("resume_clear", 64'(last_clear), 64'(5'b00001));
        check("resume_we",    64'(rf_we),      64'(1));
        clear_inputs();

        // Stall with unit 3 requesting
        set_unit(3, 1'b1, 1'b0, 32'hCAFEF00D, 5'd9);
        wb_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(g);
            check("stall_clear", 64'(last_clear), 64'(0));
            check("stall_we",    64'(rf_we),      64'(0));
        end
        wb_stall = 1'b0;
        step(g);
        check("unstall_clear", 64'(last_clear), 64'(5'b01000));
        check("unstall_wdata", 64'(rf_wdata),   64'hCAFEF00D);
        clear_inputs();

        // Asynchronous reset drops a pending write
        set_unit(2, 1'b1, 1'b0, 32'h0BADC0DE, 5'd4);
        step(g);
        check("pre_rst_we", 64'(rf_we), 64'(1));
        rst = 1'b1;
        #1;
        check("async_rst_we", 64'(rf_we), 64'(0));
        clear_inputs();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < int'(N); k++)
            set_unit(k, 1'b1, 1'b0, $urandom, REG_ADDR_W'(k + 10));
        step(g);
        check("post_rst_clear", 64'(last_clear), 64'(5'b00001));
        clear_inputs();

        // Randomized traffic; a granted unit drops its request next cycle
        g = -1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int k = 0; k < int'(N); k++) begin
                if (k == g) begin
                    cif.u_req[k] = 1'b0;
                end else if (!cif.u_req[k] && ($urandom % 2 == 0)) begin
                    set_unit(k, ($urandom % 4) != 0, ($urandom % 12) == 0,
                             $urandom, REG_ADDR_W'($urandom_range(0, 31)));
                end
            end
            wb_stall = ($urandom % 5) == 0;
            exc_ack  = ($urandom % 4) == 0;
            step(g);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/commit_arbiter.md
# commit_arbiter

Collects finished results from the execution units (ALU0..ALU4, including the CSR unit) over their commiter interface (`res`/`o_rd`/`valid`/`o_error`/`req` in, `clear` out). Selects one requester per cycle with a round-robin arbiter and writes its result to the register file through a one-stage registered writeback port. A faulting result halts commits until the trap logic acknowledges it.

## Interface
- `N_UNITS`, 5, number of execution units; must be ≥ 2.
- `XLEN`, `core_config_pkg::XLEN`, data width.
- `REG_ADDR_W`, `core_config_pkg::REG_ADDR_W`, register index width.
- `clk` in 1: core clock; all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `u_req` in N_UNITS: unit k holds a result.
- `u_valid` in N_UNITS: result carries a register write.
- `u_error` in N_UNITS: result is a fault.
- `u_res` in N_UNITS×XLEN: result data.
- `u_rd` in N_UNITS×REG_ADDR_W: destination register.
- `u_clear` out N_UNITS: one-hot grant; unit k drops `req` next cycle.
- `wb_stall` in 1: register file cannot accept this cycle.
- `rf_we` out 1, `rf_waddr` out REG_ADDR_W, `rf_wdata` out XLEN: registered writeback.
- `exc_valid` out 1: fault pending. `exc_unit` out $clog2(N_UNITS): faulting unit. `exc_data` out XLEN: its `res`.
- `exc_ack` in 1: trap logic consumed the fault.

## Operation
- States: RUN, HALT. Reset → RUN.
- RUN, `wb_stall`=0, any `u_req` set: grant first requester at or after pointer `ptr` (wrapping modulo N_UNITS). Assert `u_clear[k]` for that cycle only, then set `ptr` ← (k+1) mod N_UNITS.
- Granted unit k with `u_error`=0, `u_valid`=1, `u_rd`≠0: next cycle `rf_we`=1, `rf_waddr`=`u_rd[k]`, `rf_wdata`=`u_res[k]`.
- Granted with `u_valid`=0 or `u_rd`=0: grant and clear still issued; `rf_we` stays 0.
- Granted with `u_error`=1: no register write. Next cycle `exc_valid`=1, `exc_unit`=k, `exc_data`=`u_res[k]`. State → HALT.
- HALT: no grants; `u_clear` all 0; `exc_*` held. `exc_ack`=1 → RUN next cycle, `exc_valid` drops; arbitration resumes that cycle from the current `ptr`.
- `wb_stall`=1: no grant; `ptr` unchanged; `rf_we` deasserts next cycle.
- No requester: `ptr` unchanged.
- `exc_ack` in RUN is ignored.

## Timing
- Grant-to-write latency is 1 cycle. Throughput is 1 commit/cycle.
- `u_clear` is combinational from `u_req`, `ptr`, state and `wb_stall`. It never depends on `exc_ack` in the same cycle.
- Reset values: `u_clear`=0, `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0, `exc_valid`=0, `exc_unit`=0, `exc_data`=0, `ptr`=0, state RUN.
- `rst` asserted mid-commit drops a pending `rf_we` immediately (async). A pending fault is discarded.
- Grant and `exc_ack` in the same cycle cannot occur: grants only happen in RUN.

## Configuration
- `COMMIT_FORWARD_EN` defined: adds outputs `fwd_valid`, `fwd_rd`, `fwd_data`.
  - These combinationally mirror the current cycle's grant, under the same conditions as a future `rf_we`. This lets the issuer bypass one cycle early.
- Not defined: these ports do not exist; no extra logic.

## Structure
- `core_config_pkg` gets a `commit_state_t` enum (RUN, HALT) and a `COMMIT_UNITS` constant.
- Sub-module `rr_arbiter` (parameter N): inputs `req`, `en`; outputs one-hot `gnt`, `gnt_idx`; owns `ptr`. Reusable by the issue stage.

## Test plan
- Single request: unit 2 `req`, `valid`=1, rd=5, res=0xDEADBEEF → `u_clear[2]` same cycle; next cycle `rf_we`=1, waddr=5, wdata=0xDEADBEEF.
- Fairness: all 5 units request continuously after reset → grants in order 0,1,2,3,4,0; one commit every cycle.
- rd=0 / `valid`=0: unit 1 res=0x1234, rd=0 → `u_clear[1]` pulses; `rf_we` stays 0.
- Fault: unit 4 `error`=1, res=0x80000002 while unit 0 also requests → `exc_valid`=1, `exc_unit`=4, `exc_data`=0x80000002; unit 0 gets no grant until `exc_ack`, then is granted the following cycle.
- Stall: `wb_stall`=1 for 3 cycles with unit 3 requesting → no `u_clear`; grant in the first unstalled cycle; `ptr` unchanged during the stall.
- Async reset while `rf_we`=1 → `rf_we` falls without a clock edge; first grant after reset goes to unit 0.
